// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, exponent limits and
// bit positions of the special-case flag word and the exception vector.
package fpu_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RU  = 2'b10,
        RM_RD  = 2'b11
    } rm_e;

    localparam int EXP_BIAS = 1023;
    localparam int EXP_MAX  = 2047;

    // Positions inside the 58-bit special-case flag word
    localparam int FL_ZERO = 4;
    localparam int FL_INF  = 3;
    localparam int FL_NAN  = 2;
    localparam int FL_INV  = 1;

    // Positions inside the 4-bit exception vector {INV, OVF, UNF, INX}
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    localparam logic [62:0] MAX_FINITE_MAG = 63'h7FEF_FFFF_FFFF_FFFF;
    localparam logic [62:0] INF_MAG        = 63'h7FF0_0000_0000_0000;

    // Overflow result: infinity unless the rounding direction points toward zero
    function automatic logic [63:0] ovf_result(input logic [1:0] rm, input logic sign);
        logic to_inf;
        case (rm_e'(rm))
            RM_RNE:  to_inf = 1'b1;
            RM_RZ:   to_inf = 1'b0;
            RM_RU:   to_inf = !sign;
            default: to_inf = sign;
        endcase
        return {sign, to_inf ? INF_MAG : MAX_FINITE_MAG};
    endfunction

endpackage

// File: rtl/lzc56.sv
// Combinational leading-zero counter over a 56-bit word; all-zero input yields 56.
module lzc56 (
    input  logic [55:0] din,
    output logic [5:0]  cnt
);

    // Ascending scan: the highest set bit is the last one to write the count
    always_comb begin
        cnt = 6'd56;
        for (int i = 0; i < 56; i++) begin
            if (din[i]) cnt = 6'(55 - i);
        end
    end

endmodule

// File: rtl/add_round.sv
// Normalize / round / pack stage after the FP adder significand path.
// Three elastic pipeline stages with valid/ready on both sides.
module add_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int SIG_W = 57
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] es,
    input  logic [SIG_W-1:0] fs,
    input  logic             ss,
    input  logic [57:0]      fls,
    input  logic [1:0]       RM,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      res,
    output logic [3:0]       flags
);

    // ---------------- handshake ----------------
    logic s1_valid_reg, s2_valid_reg, out_valid_reg;
    logic s1_en, s2_en, s3_en;

    assign s3_en    = !out_valid_reg | out_ready;
    assign s2_en    = !s2_valid_reg | s3_en;
    assign s1_en    = !s1_valid_reg | s2_en;
    assign in_ready = s1_en;

    // ---------------- stage 1: normalize ----------------
    logic [5:0]         lz;
    logic [12:0]        es_m1;
    logic [5:0]         sh;
    logic [55:0]        shifted;
    logic [55:0]        n_sig_next;
    logic signed [12:0] n_exp_next;
    logic               n_zero_next;

    lzc56 u_lzc (
        .din (fs[55:0]),
        .cnt (lz)
    );

    always_comb begin
        es_m1   = {2'b00, es} - 13'd1;
        sh      = ({7'b0, lz} < es_m1) ? lz : es_m1[5:0];
        shifted = fs[55:0] << sh;
        if (fs[56]) begin
            n_sig_next = {fs[56:2], fs[1] | fs[0]};
            n_exp_next = {2'b00, es} + 13'd1;
        end else begin
            n_sig_next = shifted;
            // Shift limited by the exponent: no hidden bit means subnormal
            n_exp_next = shifted[55] ? ({2'b00, es} - {7'b0, sh}) : 13'd0;
        end
        n_zero_next = (fs[55:0] == 56'd0 && !fs[56]) | fls[FL_ZERO];
    end

    logic [55:0]        s1_sig_reg;
    logic signed [12:0] s1_exp_reg;
    logic               s1_sign_reg, s1_zero_reg, s1_tiny_reg;
    logic               s1_nan_reg, s1_inf_reg, s1_inv_reg;
    logic [50:0]        s1_pay_reg;
    logic [1:0]         s1_rm_reg;

    // ---------------- stage 2: round ----------------
    logic               g, r, st, lsb, inx, inc;
    logic [53:0]        sum;
    logic signed [12:0] r_exp_next;
    logic [51:0]        r_frac_next;

    always_comb begin
        lsb = s1_sig_reg[3];
        g   = s1_sig_reg[2];
        r   = s1_sig_reg[1];
        st  = s1_sig_reg[0];
        inx = g | r | st;
        case (rm_e'(s1_rm_reg))
            RM_RNE:  inc = g & (r | st | lsb);
            RM_RZ:   inc = 1'b0;
            RM_RU:   inc = !s1_sign_reg & inx;
            default: inc = s1_sign_reg & inx;
        endcase
        sum = {1'b0, s1_sig_reg[55:3]} + {53'd0, inc};
        // Carry out renormalizes; a subnormal reaching the hidden bit becomes exponent 1
        r_exp_next  = s1_exp_reg + 13'(sum[53])
                    + 13'((s1_exp_reg == 13'sd0) & sum[52]);
        r_frac_next = sum[53] ? 52'd0 : sum[51:0];
    end

    logic signed [12:0] s2_exp_reg;
    logic [51:0]        s2_frac_reg;
    logic               s2_sign_reg, s2_zero_reg, s2_inx_reg, s2_unf_reg;
    logic               s2_nan_reg, s2_inf_reg, s2_inv_reg;
    logic [50:0]        s2_pay_reg;
    logic [1:0]         s2_rm_reg;

    // ---------------- stage 3: special cases and packing ----------------
    logic [63:0] p_res_next;
    logic [3:0]  p_flags_next;

    always_comb begin
        p_res_next   = {s2_sign_reg, s2_exp_reg[10:0], s2_frac_reg};
        p_flags_next = 4'd0;
        if (s2_nan_reg) begin
            p_res_next            = {s2_sign_reg, 11'h7FF, 1'b1, s2_pay_reg};
            p_flags_next[FLG_INV] = s2_inv_reg;
        end else if (s2_inf_reg) begin
            p_res_next = {s2_sign_reg, INF_MAG};
        end else if (s2_zero_reg) begin
            p_res_next = {s2_sign_reg, 63'd0};
        end else if (s2_exp_reg >= $signed(13'(EXP_MAX))) begin
            p_res_next            = ovf_result(s2_rm_reg, s2_sign_reg);
            p_flags_next[FLG_OVF] = 1'b1;
            p_flags_next[FLG_INX] = 1'b1;
        end else begin
            p_flags_next[FLG_UNF] = s2_unf_reg;
            p_flags_next[FLG_INX] = s2_inx_reg;
        end
    end

    // ---------------- registers ----------------
    logic [63:0] res_reg;
    logic [3:0]  flags_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            res_reg       <= 64'd0;
            flags_reg     <= 4'd0;
        end else begin
            if (s1_en) s1_valid_reg <= in_valid;
            if (s2_en) s2_valid_reg <= s1_valid_reg;
            if (s3_en) out_valid_reg <= s2_valid_reg;
            if (s3_en && s2_valid_reg) begin
                res_reg   <= p_res_next;
                flags_reg <= p_flags_next;
            end
        end
    end

    // Data registers carry no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (s1_en) begin
            s1_sig_reg  <= n_sig_next;
            s1_exp_reg  <= n_exp_next;
            s1_sign_reg <= ss;
            s1_zero_reg <= n_zero_next;
            s1_tiny_reg <= !n_sig_next[55] & !n_zero_next;
            s1_nan_reg  <= fls[FL_NAN];
            s1_inf_reg  <= fls[FL_INF];
            s1_inv_reg  <= fls[FL_INV];
            s1_pay_reg  <= fls[55:5];
            s1_rm_reg   <= RM;
        end
        if (s2_en) begin
            s2_exp_reg  <= r_exp_next;
            s2_frac_reg <= r_frac_next;
            s2_sign_reg <= s1_sign_reg;
            s2_zero_reg <= s1_zero_reg;
            s2_inx_reg  <= inx;
            s2_unf_reg  <= s1_tiny_reg & inx;
            s2_nan_reg  <= s1_nan_reg;
            s2_inf_reg  <= s1_inf_reg;
            s2_inv_reg  <= s1_inv_reg;
            s2_pay_reg  <= s1_pay_reg;
            s2_rm_reg   <= s1_rm_reg;
        end
    end

    assign out_valid = out_valid_reg;
    assign res       = res_reg;
    assign flags     = flags_reg;

    // The quiet bit is forced, so the top payload bits and the spare flag are not used
    logic unused_fls;
    assign unused_fls = &{1'b0, fls[57:56], fls[0]};

endmodule

// File: tb/tb_add_round.sv
// Directed-vector bench for add_round: table of single operations plus
// stall/stream and reset-mid-stream sequences.
module tb_add_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] es;
    logic [56:0] fs;
    logic        ss;
    logic [57:0] fls;
    logic [1:0]  RM;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] res;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    add_round #(.EXP_W(11), .SIG_W(57)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .es        (es),
        .fs        (fs),
        .ss        (ss),
        .fls       (fls),
        .RM        (RM),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
    );

    typedef struct {
        logic [10:0] es;
        logic [56:0] fs;
        logic        ss;
        logic [57:0] fls;
        logic [1:0]  rm;
        logic [63:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [10:0] e, input logic [56:0] f,
                           input logic s, input logic [57:0] fl, input logic [1:0] m,
                           input logic [63:0] rr, input logic [3:0] ff);
        vecs[i].es = e; vecs[i].fs = f; vecs[i].ss = s; vecs[i].fls = fl;
        vecs[i].rm = m; vecs[i].res = rr; vecs[i].flg = ff;
    endtask

    task automatic drive(input int i);
        es = vecs[i].es; fs = vecs[i].fs; ss = vecs[i].ss;
        fls = vecs[i].fls; RM = vecs[i].rm;
    endtask

    initial begin
        // flags = {INV, OVF, UNF, INX}
        set_vec( 0, 11'd1023, 57'h100_0000_0000_0000, 0, 58'h0,  2'b00, 64'h4000_0000_0000_0000, 4'b0000);
        set_vec( 1, 11'd1023, 57'h080_0000_0000_000C, 0, 58'h0,  2'b00, 64'h3FF0_0000_0000_0002, 4'b0001);
        set_vec( 2, 11'd1023, 57'h080_0000_0000_000C, 0, 58'h0,  2'b01, 64'h3FF0_0000_0000_0001, 4'b0001);
        set_vec( 3, 11'd2046, 57'h100_0000_0000_0000, 0, 58'h0,  2'b00, 64'h7FF0_0000_0000_0000, 4'b0101);
        set_vec( 4, 11'd2046, 57'h100_0000_0000_0000, 0, 58'h0,  2'b01, 64'h7FEF_FFFF_FFFF_FFFF, 4'b0101);
        set_vec( 5, 11'd1023, 57'h080_0000_0000_0000, 0, 58'h6,  2'b00, 64'h7FF8_0000_0000_0000, 4'b1000);
        set_vec( 6, 11'd1023, 57'h080_0000_0000_0000, 1, 58'h10, 2'b00, 64'h8000_0000_0000_0000, 4'b0000);
        set_vec( 7, 11'd1,    57'h040_0000_0000_0000, 0, 58'h0,  2'b00, 64'h0008_0000_0000_0000, 4'b0000);
        set_vec( 8, 11'd1,    57'h040_0000_0000_0001, 0, 58'h0,  2'b10, 64'h0008_0000_0000_0001, 4'b0011);
        set_vec( 9, 11'd2046, 57'h100_0000_0000_0000, 1, 58'h0,  2'b10, 64'hFFEF_FFFF_FFFF_FFFF, 4'b0101);
        set_vec(10, 11'd2046, 57'h100_0000_0000_0000, 1, 58'h0,  2'b11, 64'hFFF0_0000_0000_0000, 4'b0101);
        set_vec(11, 11'd2046, 57'h100_0000_0000_0000, 0, 58'h0,  2'b10, 64'h7FF0_0000_0000_0000, 4'b0101);
        set_vec(12, 11'd2046, 57'h100_0000_0000_0000, 0, 58'h0,  2'b11, 64'h7FEF_FFFF_FFFF_FFFF, 4'b0101);
        set_vec(13, 11'd1023, 57'h080_0000_0000_0000, 1, 58'h8,  2'b00, 64'hFFF0_0000_0000_0000, 4'b0000);
        set_vec(14, 11'd1023, 57'h080_0000_0000_0000, 0, 58'h44, 2'b00, 64'h7FF8_0000_0000_0002, 4'b0000);
        set_vec(15, 11'd1023, 57'h0FF_FFFF_FFFF_FFFC, 0, 58'h0,  2'b00, 64'h4000_0000_0000_0000, 4'b0001);
        set_vec(16, 11'd1023, 57'h004_0000_0000_0000, 0, 58'h0,  2'b00, 64'h3FA0_0000_0000_0000, 4'b0000);
        set_vec(17, 11'd1,    57'h07F_FFFF_FFFF_FFFC, 0, 58'h0,  2'b00, 64'h0010_0000_0000_0000, 4'b0011);
        set_vec(18, 11'd5,    57'h000_0000_0000_0000, 1, 58'h0,  2'b00, 64'h8000_0000_0000_0000, 4'b0000);
        set_vec(19, 11'd1023, 57'h080_0000_0000_0004, 0, 58'h0,  2'b00, 64'h3FF0_0000_0000_0000, 4'b0001);
        set_vec(20, 11'd3,    57'h004_0000_0000_0000, 0, 58'h0,  2'b00, 64'h0002_0000_0000_0000, 4'b0000);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; drive(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset res", res, 64'd0);
        check("reset flags", 64'(flags), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);

        // Single operations, one at a time, with latency measured
        for (int i = 0; i < NV; i++) begin
            int n;
            drive(i);
            in_valid = 1'b1;
            #1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d latency", i), 64'(n), 64'd3);
            check($sformatf("v%0d res", i), res, vecs[i].res);
            check($sformatf("v%0d flags", i), 64'(flags), 64'(vecs[i].flg));
            $display("vec %0d: res=%h flags=%b latency=%0d", i, res, flags, n);
        end
        @(negedge clk);

        // Stream of 6 ops with out_ready low for cycles 2..7
        begin
            int idx = 0, oidx = 0, c = 0;
            bit seen_drop = 0, stalled = 0;
            logic [63:0] held = '0;
            while (oidx < 6 && c < 60) begin
                out_ready = !(c >= 2 && c <= 7);
                if (idx < 6) begin drive(idx); in_valid = 1'b1; end
                else in_valid = 1'b0;
                #1;
                if (stalled && out_valid)
                    check($sformatf("stall hold c%0d", c), res, held);
                stalled = out_valid && !out_ready;
                held    = res;
                if (in_valid && !in_ready && !seen_drop) begin
                    seen_drop = 1;
                    check("accepted before in_ready drop", 64'(idx), 64'd3);
                end
                if (out_valid && out_ready) begin
                    check($sformatf("stream res %0d", oidx), res, vecs[oidx].res);
                    check($sformatf("stream flags %0d", oidx), 64'(flags), 64'(vecs[oidx].flg));
                    $display("stream out %0d: res=%h flags=%b cycle=%0d", oidx, res, flags, c);
                    oidx++;
                end
                if (in_valid && in_ready) idx++;
                @(negedge clk);
                c++;
            end
            in_valid = 1'b0;
            check("stream outputs seen", 64'(oidx), 64'd6);
            check("in_ready dropped", 64'(seen_drop), 64'd1);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset pulsed while operations are in flight
        begin
            int seen = 0;
            for (int k = 0; k < 3; k++) begin
                drive(6 + k); in_valid = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("midrst out_valid", 64'(out_valid), 64'd0);
            check("midrst res", res, 64'd0);
            check("midrst flags", 64'(flags), 64'd0);
            check("midrst in_ready", 64'(in_ready), 64'd1);
            out_ready = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("midrst stale outputs", 64'(seen), 64'd0);
            $display("reset mid-stream: stale outputs=%0d", seen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/add_round.md
# add_round

Normalize/round/pack stage directly downstream of the FP adder's significand path. It accepts the adder's unrounded sum (exponent, 57-bit significand, sign, special-case flag word) and normalizes it. It then rounds it per the IEEE-754 rounding mode and emits a packed binary64 result with exception flags. It is a 3-stage elastic pipeline with valid/ready handshakes on both sides, full throughput.

## Interface
Parameters:
- `EXP_W`, 11: exponent width.
- `SIG_W`, 57: unrounded significand width.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents an operation.
- `in_ready`  out  1  stage 1 can accept.
- `es`  in  11  biased exponent of the sum, always >= 1.
- `fs`  in  57  significand:
  - [56] carry, [55] hidden bit.
  - [54:3] fraction.
  - [2] guard, [1] round, [0] sticky.
- `ss`  in  1  result sign.
- `fls`  in  58  flag word:
  - [57:5] NaN significand.
  - [4] ZERO, [3] INFs, [2] NANs, [1] INV, [0] unused.
- `RM`  in  2  rounding mode: 00 RNE, 01 RZ, 10 RU (+inf), 11 RD (-inf).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `res`  out  64  packed binary64 result.
- `flags`  out  4  {INV, OVF, UNF, INX}.

## Operation
Stage 1 (normalize):
- fs zero, or ZERO set: exact zero, sign `ss`.
- fs[56]=1: shift right 1, exponent+1, shifted-out bit ORed into sticky.
- Otherwise: left shift by min(lzc(fs[55:0]), es-1) and subtract the shift from the exponent.
  - If the hidden bit is still 0 afterwards, the result is subnormal with exponent field 0.
- The internal exponent is 13-bit signed.

Stage 2 (round), over guard/round/sticky:
- RNE: increment if G & (R | S | LSB).
- RZ: never increment.
- RU: increment if !sign & (G|R|S).
- RD: increment if sign & (G|R|S).
- Increment carry-out renormalizes: exponent+1, fraction 0.
- A subnormal that rounds into the hidden bit becomes exponent 1.
- INX = G|R|S.
- UNF = tiny before rounding & INX.

Stage 3 (special/pack), priority NANs > INFs > ZERO > overflow > finite:
- NANs: res = {ss, 11'h7FF, 1'b1, fls[55:5]} (quiet bit forced). INV = fls[1]. Other flags 0.
- INFs: ±inf; all flags 0.
- ZERO or exact zero: signed zero; all flags 0.
- Overflow (exponent >= 2047 after rounding): OVF=1, INX=1. The result depends on RM and sign:
  - RNE: ±inf.
  - RZ: ±max finite 7FEFFFFFFFFFFFFF.
  - RU: +inf for positive, -max finite for negative.
  - RD: +max finite for positive, -inf for negative.
- Finite: {sign, exp[10:0], fraction[51:0]}.

Handshake:
- A transfer occurs on valid & ready.
- A stage register loads when it is empty or its contents advance in the same cycle.
- in_ready = !s1_valid | s1_adv, where s1_adv = s2 loads.
- Once `out_valid` is high, `res`/`flags` are stable until the transfer completes.
- `RM` and `fls` travel with their operation.

## Timing
- Latency: 3 cycles from the input transfer to `out_valid`, with out_ready held high.
- Throughput: 1 operation per cycle.
- Reset: all stage valid bits clear; `out_valid`=0, `res`=0, `flags`=0, `in_ready`=1 the cycle after `rst` deasserts.
- Reset mid-operation: in-flight operations are discarded and no output is produced.
- Stall: with `out_ready` low, the pipe fills to 3 entries, then `in_ready` drops in the same cycle stage 1 becomes full and blocked.
  - No operation is lost or duplicated; order is preserved.
- Simultaneous input and output transfer when full: both occur and occupancy is unchanged.
- Pipeline data registers need no reset; valid bits and output registers do.

## Structure
- Shared package `fpu_pkg`:
  - RM encodings (`RM_RNE`, `RM_RZ`, `RM_RU`, `RM_RD`).
  - `EXP_BIAS`=1023, `EXP_MAX`=2047.
  - fls bit-index constants (`FL_ZERO`, `FL_INF`, `FL_NAN`, `FL_INV`).
  - Flag-vector index constants.
- One sub-module `lzc56`: combinational leading-zero counter, 56-bit input, 6-bit count; outputs 56 for all-zero.
- Rounding and packing stay inline.

## Test plan
- es=1023, fs[56]=1 else 0, RNE, fls=0 -> res=4000000000000000, flags=0, `out_valid` exactly 3 cycles after input.
- es=1023, fs[55]=1, fs[3]=1, fs[2]=1, RNE -> res=3FF0000000000002, INX=1. Same input with RZ -> 3FF0000000000001, INX=1.
- es=2046, fs[56]=1, ss=0:
  - RNE -> 7FF0000000000000, flags OVF|INX.
  - RZ -> 7FEFFFFFFFFFFFFF, flags OVF|INX.
- fls[2]=1, fls[1]=1, fls[57:5]=0 -> res=7FF8000000000000, flags=INV. fls[4]=1 with ss=1 -> res=8000000000000000, flags=0.
- es=1, fs[54]=1 (hidden 0) -> subnormal res=0008000000000000, flags=0. Add fs[0]=1 with RU -> 0008000000000001, UNF|INX.
- Back-to-back stream of 6 ops with out_ready low for cycles 2-7:
  - `in_ready` falls after 3 accepted.
  - All 6 results emerge in order with the correct values.
  - `rst` pulsed mid-stream -> `out_valid`=0 next cycle, no stale output.
